// File: rtl/bcd_timer.sv
// Multi-digit BCD up/down timer with run/pause/load control, terminal-count
// detection and a free-running seven-segment scan multiplexer.
module bcd_timer #(
  parameter int DIGITS      = 4,
  parameter int TICK_DIV    = 100_000_000,
  parameter int SCAN_DIV    = 100_000,
  parameter int SEXAGESIMAL = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                up,
  output logic [4*DIGITS-1:0] count,
  output logic                run,
  output logic                done,
  output logic [3:0]          scan_bcd,
  output logic [DIGITS-1:0]   scan_sel
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_timer: DIGITS must be in 2..8");
  end
  if (TICK_DIV < 2) begin : g_bad_tick
    $error("bcd_timer: TICK_DIV must be >= 2");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan
    $error("bcd_timer: SCAN_DIV must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_EXPIRED
  } state_t;

  // Digits 1 and 3 hold tens-of-seconds / tens-of-minutes in mm:ss mode.
  function automatic logic [3:0] digit_max(input int unsigned i);
    if (SEXAGESIMAL != 0 && (i == 1 || i == 3)) return 4'd5;
    return 4'd9;
  endfunction

  function automatic logic [W-1:0] max_vector();
    logic [W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < DIGITS; i++) v[4*i +: 4] = digit_max(i);
    return v;
  endfunction

  localparam logic [W-1:0] MAX_VEC = max_vector();

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           run_q, run_d;
  logic           done_q, done_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [SW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]  scan_idx_q, scan_idx_d;

  logic [W-1:0]   load_clamped;
  logic [W-1:0]   stepped;
  logic [W-1:0]   term_val;
  logic           at_term;
  logic           step_term;
  logic           tick;
  logic           carry;
  logic [3:0]     digit;

  always_comb begin
    load_clamped = load_val;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > digit_max(i)) load_clamped[4*i +: 4] = digit_max(i);
    end
  end

  // One ripple step in the direction currently selected by up.
  always_comb begin
    stepped = count_q;
    carry   = 1'b1;
    digit   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit = count_q[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (digit >= digit_max(i)) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            stepped[4*i +: 4] = digit_max(i);
          end else begin
            stepped[4*i +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    term_val  = up ? MAX_VEC : '0;
    at_term   = (count_q == term_val);
    step_term = (stepped == term_val);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    tick    = 1'b0;

    // The prescaler runs on every RUN cycle, including the one that pauses,
    // so a resume finishes exactly the remainder of the interrupted period.
    if (state_q == S_RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    if (load) begin
      state_d = S_IDLE;
      count_d = load_clamped;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_PAUSE: begin
          if (start) begin
            if (at_term) begin
              state_d = S_EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (tick) begin
            // A direction flip can leave the count already at the new
            // terminal value; expire rather than wrap the whole count.
            if (at_term) begin
              state_d = S_EXPIRED;
              done_d  = 1'b1;
            end else begin
              count_d = stepped;
              if (step_term) begin
                state_d = S_EXPIRED;
                done_d  = 1'b1;
              end else if (start) begin
                state_d = S_PAUSE;
              end
            end
          end else if (start) begin
            state_d = S_PAUSE;
          end
        end
        S_EXPIRED: begin
          state_d = S_EXPIRED;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    run_d = (state_d == S_RUN);
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IW'(1);
    end
  end

  always_comb begin
    scan_bcd = '0;
    scan_sel = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        scan_bcd    = count_q[4*i +: 4];
        scan_sel[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      run_q      <= run_d;
      done_q     <= done_d;
      presc_q    <= presc_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign count = count_q;
  assign run   = run_q;
  assign done  = done_q;

endmodule

// File: tb/tb_bcd_timer.sv
// Directed bench for bcd_timer: DIGITS=4, TICK_DIV=4, SCAN_DIV=2, with a
// second sexagesimal instance sharing the same stimulus.
module tb_bcd_timer;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        load     = 1'b0;
  logic        start    = 1'b0;
  logic        up       = 1'b0;
  logic [15:0] load_val = '0;

  logic [15:0] count, count_sx;
  logic        run, run_sx;
  logic        done, done_sx;
  logic [3:0]  scan_bcd, scan_bcd_sx;
  logic [3:0]  scan_sel, scan_sel_sx;

  int n_checks = 0;
  int n_fail   = 0;
  int n_edges  = 0;

  bcd_timer #(
    .DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .SEXAGESIMAL(0)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .up(up), .count(count), .run(run), .done(done),
    .scan_bcd(scan_bcd), .scan_sel(scan_sel)
  );

  bcd_timer #(
    .DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .SEXAGESIMAL(1)
  ) dut_sx (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .up(up), .count(count_sx), .run(run_sx), .done(done_sx),
    .scan_bcd(scan_bcd_sx), .scan_sel(scan_sel_sx)
  );

  always #5 clk = ~clk;

  // Edges since reset release, used to know the scan phase.
  always @(posedge clk or posedge rst) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    cyc();
    load     = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [3:0] exp_sel [4];
  logic [3:0] exp_bcd [4];

  initial begin
    exp_sel[0] = 4'b1110; exp_sel[1] = 4'b1101; exp_sel[2] = 4'b1011; exp_sel[3] = 4'b0111;
    exp_bcd[0] = 4'h4;    exp_bcd[1] = 4'h3;    exp_bcd[2] = 4'h2;    exp_bcd[3] = 4'h1;

    // Reset state
    #2;
    check("rst_count",    32'(count),       32'h0000);
    check("rst_run",      32'(run),         32'h0);
    check("rst_done",     32'(done),        32'h0);
    check("rst_sel",      32'(scan_sel),    32'he);
    check("rst_bcd",      32'(scan_bcd),    32'h0);
    check("rst_count_sx", 32'(count_sx),    32'h0000);
    check("rst_run_sx",   32'(run_sx),      32'h0);
    check("rst_sel_sx",   32'(scan_sel_sx), 32'he);
    check("rst_bcd_sx",   32'(scan_bcd_sx), 32'h0);
    cyc(2);
    rst = 1'b0;

    // Countdown to zero
    up = 1'b0;
    pulse_load(16'h0002);
    check("cd_load",     32'(count), 32'h0002);
    check("cd_idle_run", 32'(run),   32'h0);
    pulse_start();
    check("cd_run",      32'(run),   32'h1);
    cyc(3);
    check("cd_e3",       32'(count), 32'h0002);
    cyc();
    check("cd_e4",       32'(count), 32'h0001);
    check("cd_e4_done",  32'(done),  32'h0);
    cyc(4);
    check("cd_e8",       32'(count), 32'h0000);
    check("cd_e8_done",  32'(done),  32'h1);
    check("cd_e8_run",   32'(run),   32'h0);
    cyc();
    check("cd_done_1cy", 32'(done),  32'h0);
    pulse_start();
    check("cd_exp_run",  32'(run),   32'h0);
    check("cd_exp_done", 32'(done),  32'h0);
    cyc(8);
    check("cd_exp_hold", 32'(count), 32'h0000);
    check("cd_exp_run2", 32'(run),   32'h0);

    // Sexagesimal borrow: 01:00 down to 00:00 takes 60 ticks
    pulse_load(16'h0100);
    check("sx_load", 32'(count_sx), 32'h0100);
    pulse_start();
    cyc(4);
    check("sx_t1",   32'(count_sx), 32'h0059);
    cyc(36);
    check("sx_t10",  32'(count_sx), 32'h0050);
    check("dec_t10", 32'(count),    32'h0090);
    cyc(199);
    check("sx_t60m1",      32'(count_sx), 32'h0001);
    check("sx_t60m1_done", 32'(done_sx),  32'h0);
    cyc();
    check("sx_t60",      32'(count_sx), 32'h0000);
    check("sx_t60_done", 32'(done_sx),  32'h1);
    check("sx_t60_run",  32'(run_sx),   32'h0);

    // Pause/resume: prescaler keeps its partial period
    pulse_load(16'h0050);
    pulse_start();
    cyc(2);
    pulse_start();
    check("pr_pause_run", 32'(run),   32'h0);
    cyc(20);
    check("pr_hold",      32'(count), 32'h0050);
    check("pr_hold_run",  32'(run),   32'h0);
    pulse_start();
    check("pr_resume",    32'(run),   32'h1);
    check("pr_resume_ct", 32'(count), 32'h0050);
    cyc();
    check("pr_step1",     32'(count), 32'h0049);
    cyc(3);
    check("pr_wait",      32'(count), 32'h0049);
    cyc();
    check("pr_step2",     32'(count), 32'h0048);

    // Direction change mid-run
    pulse_load(16'h0005);
    pulse_start();
    cyc(4);
    check("dir_down", 32'(count), 32'h0004);
    up = 1'b1;
    cyc(4);
    check("dir_up",   32'(count), 32'h0005);

    // Up terminal with clamp
    pulse_load(16'h9A98);
    check("up_clamp",    32'(count),    32'h9998);
    check("up_clamp_sx", 32'(count_sx), 32'h5958);
    pulse_start();
    cyc(3);
    check("up_e3",       32'(count), 32'h9998);
    cyc();
    check("up_e4",       32'(count), 32'h9999);
    check("up_e4_done",  32'(done),  32'h1);
    check("up_e4_run",   32'(run),   32'h0);

    // Immediate expiry, up and down
    pulse_load(16'h9999);
    pulse_start();
    check("imm_up_done", 32'(done),  32'h1);
    check("imm_up_run",  32'(run),   32'h0);
    check("imm_up_cnt",  32'(count), 32'h9999);
    cyc();
    check("imm_up_d1",   32'(done),  32'h0);
    up = 1'b0;
    pulse_load(16'h0000);
    pulse_start();
    check("imm_dn_done", 32'(done),  32'h1);
    check("imm_dn_run",  32'(run),   32'h0);

    // Load beats start in the same cycle
    pulse_load(16'h0300);
    pulse_start();
    cyc();
    load     = 1'b1;
    start    = 1'b1;
    load_val = 16'h0777;
    cyc();
    load     = 1'b0;
    start    = 1'b0;
    check("lp_count", 32'(count), 32'h0777);
    check("lp_run",   32'(run),   32'h0);
    cyc(8);
    check("lp_hold",  32'(count), 32'h0777);
    check("lp_run2",  32'(run),   32'h0);

    // Asynchronous reset during RUN, observed before the next edge
    pulse_start();
    check("ar_running", 32'(run), 32'h1);
    cyc(2);
    #2;
    rst = 1'b1;
    #1;
    check("ar_count", 32'(count),    32'h0000);
    check("ar_run",   32'(run),      32'h0);
    check("ar_done",  32'(done),     32'h0);
    check("ar_sel",   32'(scan_sel), 32'he);
    check("ar_bcd",   32'(scan_bcd), 32'h0);
    cyc();
    rst = 1'b0;
    cyc(6);
    check("ar_nodone", 32'(done),  32'h0);
    check("ar_idle",   32'(count), 32'h0000);

    // Scan multiplexer
    pulse_load(16'h1234);
    for (int k = 0; k < 8 && (n_edges % 8) != 0; k++) cyc();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("scan_sel%0d", k), 32'(scan_sel), 32'(exp_sel[k/2]));
      check($sformatf("scan_bcd%0d", k), 32'(scan_bcd), 32'(exp_bcd[k/2]));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
